// File: rtl/dcf77_pkg.sv
// Shared types, tick thresholds and helpers for the DCF77 second-pulse decoder.
package dcf77_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } dcf_state_e;

  localparam logic [1:0] DEB_DEPTH  = 2'd3;

  localparam logic [7:0] W0_MIN     = 8'd5;
  localparam logic [7:0] W0_MAX     = 8'd14;
  localparam logic [7:0] W1_MIN     = 8'd15;
  localparam logic [7:0] W1_MAX     = 8'd25;
  localparam logic [7:0] P_NORM_MIN = 8'd90;
  localparam logic [7:0] P_NORM_MAX = 8'd110;
  localparam logic [7:0] P_MARK_MIN = 8'd180;
  localparam logic [7:0] P_MARK_MAX = 8'd210;
  localparam logic [7:0] P_TIMEOUT  = 8'd250;

  localparam logic [5:0] SEC_MAX    = 6'd59;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [5:0] sec_inc(input logic [5:0] v);
    return (v >= SEC_MAX) ? SEC_MAX : v + 6'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dcf77_pulse_decoder.sv
// DCF77 second-pulse decoder: debounces the demodulated carrier, classifies
// pulse widths into bits and pulse periods into normal/minute-marker/fault.
module dcf77_pulse_decoder
  import dcf77_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       dcf_in,
  output logic       bit_valid,
  output logic       bit_value,
  output logic       bit_err,
  output logic       minute_start,
  output logic [5:0] sec_idx,
  output logic       synced
);

  logic       dcf_s;
  logic       filt_q, filt_d;
  logic [1:0] deb_cnt_q, deb_cnt_d;
  logic       armed_q;
  dcf_state_e state_q;
  logic [7:0] width_q, period_q;
  logic [7:0] width_n, period_n;
  logic [5:0] sec_q;
  logic       synced_q;
  logic       bit_valid_q, bit_value_q, bit_err_q, minute_q;
  logic       rise, fall;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (dcf_in),
    .q_o (dcf_s)
  );

  // The filtered level flips on the DEB_DEPTH-th consecutive differing tick.
  always_comb begin
    deb_cnt_d = 2'd0;
    filt_d    = filt_q;
    if (dcf_s != filt_q) begin
      if (deb_cnt_q == DEB_DEPTH - 2'd1) filt_d = dcf_s;
      else                               deb_cnt_d = deb_cnt_q + 2'd1;
    end
  end

  assign rise     = clk_en &  filt_d & ~filt_q;
  assign fall     = clk_en & ~filt_d &  filt_q;
  assign width_n  = sat_inc8(width_q);
  assign period_n = sat_inc8(period_q);

  // armed_q blocks a pulse already in progress at reset release from being measured.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q      <= 1'b0;
      deb_cnt_q   <= 2'd0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      width_q     <= 8'd0;
      period_q    <= 8'd0;
      sec_q       <= 6'd0;
      synced_q    <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_value_q <= 1'b0;
      bit_err_q   <= 1'b0;
      minute_q    <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      bit_err_q   <= 1'b0;
      minute_q    <= 1'b0;
      if (clk_en) begin
        filt_q    <= filt_d;
        deb_cnt_q <= deb_cnt_d;
        if (!filt_q && !dcf_s) armed_q <= 1'b1;
        unique case (state_q)
          ST_IDLE: begin
            if (rise && armed_q) begin
              state_q  <= ST_HIGH;
              width_q  <= 8'd0;
              period_q <= 8'd0;
            end
          end
          ST_HIGH: begin
            period_q <= period_n;
            if (fall) begin
              state_q <= ST_LOW;
              if (width_n >= W0_MIN && width_n <= W0_MAX) begin
                bit_valid_q <= 1'b1;
                bit_value_q <= 1'b0;
                sec_q       <= sec_inc(sec_q);
              end else if (width_n >= W1_MIN && width_n <= W1_MAX) begin
                bit_valid_q <= 1'b1;
                bit_value_q <= 1'b1;
                sec_q       <= sec_inc(sec_q);
              end else begin
                bit_err_q <= 1'b1;
              end
            end else begin
              width_q <= width_n;
            end
          end
          ST_LOW: begin
            if (rise) begin
              state_q  <= ST_HIGH;
              width_q  <= 8'd0;
              period_q <= 8'd0;
              if (period_n >= P_MARK_MIN && period_n <= P_MARK_MAX) begin
                minute_q <= 1'b1;
                synced_q <= 1'b1;
                sec_q    <= 6'd0;
              end else if (!(period_n >= P_NORM_MIN && period_n <= P_NORM_MAX)) begin
                synced_q <= 1'b0;
              end
            end else if (period_n >= P_TIMEOUT) begin
              state_q  <= ST_IDLE;
              synced_q <= 1'b0;
            end else begin
              period_q <= period_n;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bit_valid    = bit_valid_q;
  assign bit_value    = bit_value_q;
  assign bit_err      = bit_err_q;
  assign minute_start = minute_q;
  assign sec_idx      = sec_q;
  assign synced       = synced_q;

endmodule

// File: doc/dcf77_pulse_decoder.md
DCF77_PULSE_DECODER -- requirements
Module: dcf77_pulse_decoder

Interface
REQ-001 SHALL have port clk, input, 1, system clock (24 MHz).
REQ-002 SHALL have port rst, input, 1, reset; one clock, synchronous, active-high.
REQ-003 SHALL have port clk_en, input, 1, 10 ms tick; one clk wide, period 240000 clk.
REQ-004 SHALL have port dcf_in, input, 1, asynchronous DCF77 demodulator output; 1 = carrier reduced (second pulse).
REQ-005 SHALL have port bit_valid, output, 1, one-clk strobe; a second pulse has been classified.
REQ-006 SHALL have port bit_value, output, 1, decoded bit: 0 = 100 ms pulse, 1 = 200 ms pulse; meaningful only with bit_valid.
REQ-007 SHALL have port bit_err, output, 1, one-clk strobe; pulse width out of range.
REQ-008 SHALL have port minute_start, output, 1, one-clk strobe; minute marker (missing 59th pulse) detected.
REQ-009 SHALL have port sec_idx, output, 6, index of the current bit within the minute (0..59).
REQ-010 SHALL have port synced, output, 1, level; a minute marker has been seen since the last timing fault.

Function
REQ-011 SHALL resynchronise dcf_in through a two-flop synchroniser on clk before any use.
REQ-012 SHALL sample the synchronised input only in cycles where clk_en=1; all counters SHALL advance only on clk_en.
REQ-013 SHALL debounce: filtered level changes only after 3 consecutive equal ticks (30 ms) differ from the current filtered level.
REQ-014 SHALL run FSM IDLE -> HIGH on filtered rise; HIGH -> LOW on filtered fall; LOW -> HIGH on filtered rise; LOW -> IDLE on timeout.
REQ-015 SHALL count ticks in HIGH in an 8-bit width counter, saturating at 255.
REQ-016 SHALL count ticks between successive filtered rises in an 8-bit period counter, saturating at 255.
REQ-017 On the HIGH -> LOW transition, SHALL classify width W (ticks, measured from debounced edges): 5..14 gives bit 0; 15..25 gives bit 1; otherwise bit_err.
REQ-018 On a rise in LOW, SHALL classify period P (ticks): 90..110 is normal; 180..210 is minute marker; otherwise a timing fault.
REQ-019 A timing fault SHALL clear synced and leave the FSM in HIGH.
REQ-020 A minute marker SHALL pulse minute_start, set synced and reset sec_idx to 0.
REQ-021 Timeout: if P reaches 250 ticks in LOW, SHALL go to IDLE and clear synced; sec_idx is held.
REQ-022 sec_idx SHALL increment after each bit_valid and saturate at 59, which covers the leap-second minute.
REQ-023 All strobes SHALL be registered and asserted exactly in the clk cycle following the clk_en cycle that caused them.
REQ-024 bit_valid and bit_err SHALL be mutually exclusive.
REQ-025 If a minute marker and a bit strobe occur in the same tick, minute_start SHALL be applied first, and the strobe SHALL then act on sec_idx=0.
REQ-026 The first rise out of IDLE SHALL NOT be period-classified; it only starts counting.

Reset
REQ-027 While rst=1: FSM=IDLE, synchroniser and filter = 0, counters = 0, sec_idx = 0, synced = 0, all strobes = 0.
REQ-028 Reset asserted mid-pulse SHALL discard the measurement; no strobe SHALL follow reset release until a new full pulse is observed.
REQ-029 rst SHALL take priority over clk_en.

Structure
REQ-030 Package dcf77_pkg SHALL hold the FSM state enum, the tick thresholds (5/14/15/25, 90/110, 180/210, 250) and the debounce depth 3.
REQ-031 The synchroniser SHALL be a sub-module named sync_2ff.
REQ-032 The block SHALL contain no tick generation; clk_en SHALL come from the existing 10 ms enable generator.

Verification
REQ-033 10 pulses of 10-tick width at 100-tick period -> 10 bit_valid with bit_value=0, no bit_err, synced stays 0.
REQ-034 One 20-tick pulse, then a 190-tick gap, then a 10-tick pulse -> bit_value=1, then minute_start, sec_idx=0, synced=1, then bit_valid with value 0 and sec_idx=1.
REQ-035 A 2-tick glitch during LOW and a 1-tick dropout during HIGH -> no FSM change, no strobes.
REQ-036 A 40-tick pulse -> bit_err single strobe, no bit_valid; a 130-tick period while synced=1 -> synced=0.
REQ-037 dcf_in held at 0 for 300 ticks after sync -> FSM IDLE and synced=0 at tick 250; sec_idx unchanged.
REQ-038 rst asserted at tick 7 of a pulse -> all outputs 0 next cycle; no strobe before the next complete pulse.
